// File: rtl/mem_stage_sram.sv
// Memory pipeline stage driving an asynchronous SRAM with a fixed multi-cycle access window.
// Optional one-entry last-read buffer compiled in with `define SRAM_LAST_READ_BUF_EN.
module mem_stage_sram #(
  parameter int WORD_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 16,
  parameter int WAIT_CYCLES     = 4,
  parameter int MEM_BASE        = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WORD_WIDTH-1:0]      ALU_res,
  input  logic [WORD_WIDTH-1:0]      val_Rm,
  input  logic                       mem_read_in,
  input  logic                       mem_write_in,
  input  logic                       WB_en_in,
  input  logic [3:0]                 dst_in,
  output logic                       WB_en_out,
  output logic                       mem_read_out,
  output logic [3:0]                 dst_out,
  output logic [WORD_WIDTH-1:0]      mem_result,
  output logic                       ready,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0]      sram_wdata,
  input  logic [WORD_WIDTH-1:0]      sram_rdata,
  output logic                       sram_we_n,
  output logic                       sram_oe_n
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [3:0]            CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] BASE     = WORD_WIDTH'(MEM_BASE);

  logic [1:0]                 state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       we_q, we_d;
  logic [WORD_WIDTH-1:0]      result_q, result_d;

  logic                       req;
  logic                       hit;
  logic                       in_access;
  logic                       rd_done;
  logic [SRAM_ADDR_WIDTH-1:0] word_addr;

  assign req       = mem_read_in | mem_write_in;
  assign word_addr = SRAM_ADDR_WIDTH'((ALU_res - BASE) >> 2);
  assign in_access = (state_q == S_ACCESS);
  assign rd_done   = in_access && (cnt_q == '0) && !we_q;

`ifdef SRAM_LAST_READ_BUF_EN
  logic                       buf_valid_q, buf_valid_d;
  logic [SRAM_ADDR_WIDTH-1:0] buf_tag_q, buf_tag_d;
  logic [WORD_WIDTH-1:0]      buf_data_q, buf_data_d;

  assign hit = (state_q == S_IDLE) && mem_read_in && !mem_write_in &&
               buf_valid_q && (buf_tag_q == word_addr);

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if ((state_q == S_IDLE) && mem_write_in) begin
      buf_valid_d = 1'b0;
    end else if (rd_done) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = addr_q;
      buf_data_d  = sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign mem_result = hit ? buf_data_q : result_q;
`else
  assign hit        = 1'b0;
  assign mem_result = result_q;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_LOAD;
          addr_d  = word_addr;
          wdata_d = val_Rm;
          we_d    = mem_write_in;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!we_q) result_d = sram_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      result_q <= result_d;
    end
  end

  // A buffer hit counts as a completed request, so the stage advances without stalling.
  assign ready = ((state_q == S_IDLE) && (!req || hit)) || (state_q == S_DONE);

  assign sram_addr  = in_access ? addr_q : '0;
  assign sram_wdata = in_access ? wdata_q : '0;
  assign sram_we_n  = !(in_access && we_q);
  assign sram_oe_n  = !(in_access && !we_q);

  assign WB_en_out    = WB_en_in;
  assign mem_read_out = mem_read_in;
  assign dst_out      = dst_in;

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 Parameter WORD_WIDTH, default 32, data and address width of the pipeline side.
REQ-002 Parameter SRAM_ADDR_WIDTH, default 16, word-address width of the SRAM port.
REQ-003 Parameter WAIT_CYCLES, default 4, SRAM access cycles per transaction (legal range 1..15).
REQ-004 Parameter MEM_BASE, default 1024, byte address mapped to SRAM word 0.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 ALU_res  in  WORD_WIDTH  byte address from the execute-stage register.
REQ-008 val_Rm  in  WORD_WIDTH  store data.
REQ-009 mem_read_in, mem_write_in  in  1 each  access request strobes, held stable while ready=0.
REQ-010 WB_en_in  in  1 and dst_in  in  4  writeback controls.
REQ-011 WB_en_out, mem_read_out  out  1 each and dst_out  out  4  combinational pass-through of the matching inputs.
REQ-012 mem_result  out  WORD_WIDTH  load data.
REQ-013 ready  out  1  high = stage can advance; low = freeze all upstream pipeline registers.
REQ-014 sram_addr  out  SRAM_ADDR_WIDTH; sram_wdata  out  WORD_WIDTH; sram_rdata  in  WORD_WIDTH; sram_we_n, sram_oe_n  out  1 each, active low.

Function
REQ-015 req = mem_read_in | mem_write_in; when both are asserted, the access is a write.
REQ-016 Word address = (ALU_res - MEM_BASE) bits [SRAM_ADDR_WIDTH+1:2]; bits [1:0] are ignored; the result wraps modulo 2^SRAM_ADDR_WIDTH.
REQ-017 FSM states: IDLE, ACCESS, DONE.
REQ-018 IDLE: when req=1, latch the address, data and direction, load the wait counter with WAIT_CYCLES-1, and go to ACCESS; otherwise stay in IDLE.
REQ-019 ACCESS: drive sram_addr and sram_wdata from the latches and assert the strobe for the latched direction only; decrement the counter each cycle; at counter 0 go to DONE and, for a read, register sram_rdata into mem_result.
REQ-020 DONE: strobes deasserted, ready=1, unconditional return to IDLE.
REQ-021 ready = (IDLE & ~req) | DONE, combinational.
REQ-022 An uncached access holds ready low for exactly WAIT_CYCLES+1 consecutive cycles.
REQ-023 mem_result holds its value until the next read completes; writes do not alter it.
REQ-024 A request present in IDLE on the cycle immediately after DONE starts a new transaction (back-to-back accesses).
REQ-025 Outside ACCESS: sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.

Reset
REQ-026 When rst=1 at a clock edge: FSM goes to IDLE, counter=0, mem_result=0, and all latches are cleared; this applies even when the FSM is in ACCESS or DONE.
REQ-027 After reset the strobes read 1, sram_addr=0, and ready follows REQ-021.

Configuration
REQ-028 Macro SRAM_LAST_READ_BUF_EN compiles in a one-entry read buffer (valid bit, word-address tag, data).
REQ-029 With the macro: a read in IDLE whose address matches a valid tag is a hit; on a hit ready=1 in the same cycle, mem_result is driven combinationally from the buffer, no SRAM access occurs, and the FSM stays in IDLE.
REQ-030 With the macro: every completed SRAM read loads the buffer; any write clears the valid bit; reset clears the valid bit.
REQ-031 Without the macro: no buffer is present, and every read follows REQ-018..REQ-022.

Verification
REQ-032 WAIT_CYCLES=4; write ALU_res=1028, val_Rm=0xDEADBEEF -> sram_addr=1, sram_we_n low for 4 cycles, ready low for 5 cycles.
REQ-033 Read ALU_res=1028 with sram_rdata=0xDEADBEEF -> sram_oe_n low for 4 cycles, mem_result=0xDEADBEEF from the DONE cycle onward.
REQ-034 mem_read_in=mem_write_in=1 at ALU_res=1024 -> write performed to sram_addr 0, sram_oe_n stays 1.
REQ-035 rst asserted in the 2nd ACCESS cycle -> next cycle in IDLE, strobes=1, mem_result=0, ready=1 with no request.
REQ-036 SRAM_LAST_READ_BUF_EN defined: two reads of 1032 -> second read has ready=1 and no strobe activity; after a write to any address, a third read of 1032 stalls 5 cycles.
